// File: rtl/pri_sched_pkg.sv
// Shared constants and state encoding for the priority weighted round-robin scheduler.
package pri_sched_pkg;

  localparam int PRI_NUM        = 8;
  localparam int WRR_WEIGHT_NUM = 8;
  localparam int WW             = $clog2(WRR_WEIGHT_NUM) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first: first set request at or above ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] pos;

  // Scan offsets from far to near so the nearest hit to the pointer wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = IW'((int'(ptr_i) + k) % N);
      if (req_i[pos]) begin
        found_o    = 1'b1;
        idx_o      = pos;
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_wrr_sched.sv
// Weighted round-robin grant scheduler: per-queue credits reloaded from weights
// when no requesting queue has credit left; one packet per grant.
module pri_wrr_sched #(
  parameter  int PRI_NUM        = pri_sched_pkg::PRI_NUM,
  parameter  int WRR_WEIGHT_NUM = pri_sched_pkg::WRR_WEIGHT_NUM,
  localparam int WW             = $clog2(WRR_WEIGHT_NUM) + 1,
  localparam int IW             = $clog2(PRI_NUM)
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [PRI_NUM-1:0]    iReq,
  input  logic [PRI_NUM*WW-1:0] iWeightPld,
  input  logic                  iWeightLoad,
  output logic                  oGntVld,
  output logic [PRI_NUM-1:0]    oGnt,
  output logic [IW-1:0]         oGntIdx,
  input  logic                  iGntAck,
  input  logic                  iPktEnd,
  output logic                  oBusy
);

  import pri_sched_pkg::*;

  state_e              state_q, state_d;
  logic [WW-1:0]       weight_q [PRI_NUM];
  logic [WW-1:0]       weight_d [PRI_NUM];
  logic [WW-1:0]       credit_q [PRI_NUM];
  logic [WW-1:0]       credit_d [PRI_NUM];
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [PRI_NUM-1:0]  gnt_q, gnt_d;

  logic [PRI_NUM-1:0]  effective, eligible, pick_gnt;
  logic [IW-1:0]       pick_idx, idx_inc;
  logic                pick_found;
  logic [WW-1:0]       cur_credit, left_credit;

  genvar gi;
  generate
    for (gi = 0; gi < PRI_NUM; gi++) begin : g_queue
      logic [WW-1:0] pld;
      assign pld            = iWeightPld[gi*WW +: WW];
      assign effective[gi]  = iReq[gi] & (weight_q[gi] != '0);
      assign eligible[gi]   = effective[gi] & (credit_q[gi] != '0);

      always_comb begin
        weight_d[gi] = weight_q[gi];
        if (iWeightLoad) begin
          weight_d[gi] = (pld > WW'(WRR_WEIGHT_NUM)) ? WW'(WRR_WEIGHT_NUM) : pld;
        end
      end
    end
  endgenerate

  rr_pick #(.N(PRI_NUM), .IW(IW)) u_pick (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      for (int i = 0; i < PRI_NUM; i++) begin
        weight_q[i] <= WW'(1);
        credit_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      weight_q <= weight_d;
      credit_q <= credit_d;
    end
  end

  assign idx_inc = (idx_q == IW'(PRI_NUM - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    credit_d    = credit_q;
    cur_credit  = credit_q[idx_q];
    left_credit = (cur_credit != '0) ? cur_credit - 1'b1 : '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
        end else if (|effective) begin
          // Refresh reads the registered weights, so a coincident load waits a round.
          credit_d = weight_q;
        end
      end
      GRANT: begin
        if (iGntAck) begin
          credit_d[idx_q] = left_credit;
          ptr_d           = (left_credit != '0) ? idx_q : idx_inc;
          gnt_d           = '0;
          state_d         = iPktEnd ? IDLE : XFER;
        end
      end
      XFER: begin
        if (iPktEnd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oGntVld = (state_q == GRANT);
    oGnt    = (state_q == GRANT) ? gnt_q : '0;
    oGntIdx = idx_q;
    oBusy   = (state_q != IDLE);
  end

endmodule

// File: tb/tb_pri_wrr_sched.sv
// Directed scoreboard bench for pri_wrr_sched: stimulus queues expected grants, a monitor pops them.
module tb_pri_wrr_sched;

  localparam int N  = 8;
  localparam int WW = 4;
  localparam int IW = 3;

  logic            iClk = 1'b0;
  logic            iRst = 1'b1;
  logic [N-1:0]    iReq = '0;
  logic [N*WW-1:0] iWeightPld = '0;
  logic            iWeightLoad = 1'b0;
  logic            oGntVld;
  logic [N-1:0]    oGnt;
  logic [IW-1:0]   oGntIdx;
  logic            iGntAck = 1'b0;
  logic            iPktEnd = 1'b0;
  logic            oBusy;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  pri_wrr_sched dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iReq        (iReq),
    .iWeightPld  (iWeightPld),
    .iWeightLoad (iWeightLoad),
    .oGntVld     (oGntVld),
    .oGnt        (oGnt),
    .oGntIdx     (oGntIdx),
    .iGntAck     (iGntAck),
    .iPktEnd     (iPktEnd),
    .oBusy       (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every new grant pops one expected queue index.
  initial begin
    logic prev_vld;
    int   e;
    prev_vld = 1'b0;
    forever begin
      @(negedge iClk);
      if (iRst !== 1'b0) begin
        prev_vld = 1'b0;
      end else begin
        if (oGntVld && !prev_vld) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got idx %0d, required no grant", oGntIdx);
          end else begin
            e = exp_q.pop_front();
            check("gnt_onehot", 32'(oGnt), 32'(1) << e);
            check("gnt_idx", 32'(oGntIdx), 32'(e));
            $display("grant q%0d oGnt=%02h oGntIdx=%0d", e, oGnt, oGntIdx);
          end
        end
        prev_vld = oGntVld;
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    iReq = '0;
    iGntAck = 1'b0;
    iPktEnd = 1'b0;
    iWeightLoad = 1'b0;
    tick();
    tick();
    iRst = 1'b0;
  endtask

  task automatic load_weights(input logic [N*WW-1:0] w);
    iWeightPld = w;
    iWeightLoad = 1'b1;
    tick();
    iWeightLoad = 1'b0;
  endtask

  task automatic wait_grant(input int idx, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    exp_q.push_back(idx);
    while (!oGntVld && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic ack(input logic pkt_end);
    iGntAck = 1'b1;
    iPktEnd = pkt_end;
    tick();
    iGntAck = 1'b0;
    iPktEnd = 1'b0;
    check("ack_vld_drop", 32'(oGntVld), 32'(0));
    check("ack_gnt_clear", 32'(oGnt), 32'(0));
    check("ack_busy", 32'(oBusy), 32'(!pkt_end));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int seq_q[8];
    int seq_l[8];
    logic stable, seen_vld, seen_busy;

    // Reset state and first request needing a refresh.
    do_reset();
    check("rst_vld", 32'(oGntVld), 32'(0));
    check("rst_gnt", 32'(oGnt), 32'(0));
    check("rst_idx", 32'(oGntIdx), 32'(0));
    check("rst_busy", 32'(oBusy), 32'(0));
    iReq = 8'h01;
    wait_grant(0, 2, "single_q0");
    ack(1'b1);
    iReq = '0;
    tick();
    check("single_idle", 32'(oBusy), 32'(0));

    // Weights q0=3, q1=1.
    do_reset();
    load_weights(32'h1111_1113);
    iReq = 8'h03;
    seq_q = '{0, 0, 0, 1, 0, 0, 0, 1};
    seq_l = '{2, 1, 1, 1, 2, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      wait_grant(seq_q[i], seq_l[i], "wrr31");
      ack(1'b1);
    end
    iReq = '0;

    // All queues, weight 1: 0..7 then refresh, back to 0.
    do_reset();
    iReq = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      wait_grant(i, (i == 0) ? 2 : 1, "rr_all");
      ack(1'b1);
    end
    wait_grant(0, 2, "rr_wrap");
    ack(1'b1);
    iReq = '0;

    // Weight above maximum clamps to 8.
    do_reset();
    load_weights(32'h1111_111F);
    iReq = 8'h01;
    for (int i = 0; i < 9; i++) begin
      wait_grant(0, (i == 0 || i == 8) ? 2 : 1, "clamp");
      ack(1'b1);
    end
    iReq = '0;

    // Weight load coincident with refresh: old weight used first.
    do_reset();
    iReq = 8'h01;
    iWeightPld = 32'h1111_1112;
    iWeightLoad = 1'b1;
    tick();
    iWeightLoad = 1'b0;
    wait_grant(0, 1, "wload_first");
    ack(1'b1);
    wait_grant(0, 2, "wload_new_a");
    ack(1'b1);
    wait_grant(0, 1, "wload_new_b");
    ack(1'b1);
    wait_grant(0, 2, "wload_new_c");
    ack(1'b1);
    iReq = '0;

    // Weight 0 disables the queue.
    do_reset();
    load_weights(32'h1111_1011);
    iReq = 8'h04;
    seen_vld = 1'b0;
    seen_busy = 1'b0;
    repeat (10) begin
      tick();
      seen_vld |= oGntVld;
      seen_busy |= oBusy;
    end
    check("disabled_vld", 32'(seen_vld), 32'(0));
    check("disabled_busy", 32'(seen_busy), 32'(0));
    iReq = '0;

    // Grant held stable while acknowledge is delayed, then XFER.
    do_reset();
    iReq = 8'h20;
    wait_grant(5, 2, "hold_q5");
    iReq = '0;
    stable = 1'b1;
    repeat (4) begin
      tick();
      if (oGnt !== 8'h20 || oGntVld !== 1'b1 || oGntIdx !== 3'd5) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'(1));
    ack(1'b0);
    repeat (3) tick();
    check("xfer_busy", 32'(oBusy), 32'(1));
    check("xfer_vld", 32'(oGntVld), 32'(0));
    iPktEnd = 1'b1;
    tick();
    iPktEnd = 1'b0;
    check("xfer_end_busy", 32'(oBusy), 32'(0));

    // Reset during XFER, then fresh refresh needed.
    do_reset();
    iReq = 8'h08;
    wait_grant(3, 2, "pre_rst_q3");
    ack(1'b0);
    tick();
    iRst = 1'b1;
    tick();
    check("midrst_vld", 32'(oGntVld), 32'(0));
    check("midrst_gnt", 32'(oGnt), 32'(0));
    check("midrst_idx", 32'(oGntIdx), 32'(0));
    check("midrst_busy", 32'(oBusy), 32'(0));
    iRst = 1'b0;
    wait_grant(3, 2, "post_rst_q3");
    ack(1'b1);
    iReq = '0;
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
